// File: rtl/can_frame_decoder_if.sv
// rtl/can_frame_decoder_if.sv - frame-in / decoded-frame-out bundle for can_frame_decoder
interface can_frame_decoder_if #(
    parameter int FRAME_W = 79
);
    logic               i_Rx_DV;
    logic [FRAME_W-1:0] i_Rx_Frame;
    logic               i_Frame_Ready;
    logic               o_Frame_Valid;
    logic [10:0]        o_Id;
    logic               o_Rtr;
    logic               o_Ide;
    logic [3:0]         o_Dlc;
    logic [39:0]        o_Data;
    logic               o_Crc_Err;
    logic               o_Dlc_Err;
    logic               o_Overrun;
    logic               o_Filtered;
    logic               o_Busy;

    modport master (
        output i_Rx_DV, i_Rx_Frame, i_Frame_Ready,
        input  o_Frame_Valid, o_Id, o_Rtr, o_Ide, o_Dlc, o_Data,
               o_Crc_Err, o_Dlc_Err, o_Overrun, o_Filtered, o_Busy
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Frame, i_Frame_Ready,
        output o_Frame_Valid, o_Id, o_Rtr, o_Ide, o_Dlc, o_Data,
               o_Crc_Err, o_Dlc_Err, o_Overrun, o_Filtered, o_Busy
    );
endinterface

// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - serial CRC-15 check and field extraction of a captured CAN frame
// Optional acceptance filter: CAN_DEC_ID_FILTER_EN
module can_frame_decoder #(
    parameter int          FRAME_W  = 79,
    parameter logic [10:0] ACC_CODE = 11'h000,
    parameter logic [10:0] ACC_MASK = 11'h000
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    can_frame_decoder_if.slave   frm
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CRC   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [14:0]        crc_q, crc_d;
    logic [6:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [10:0]        id_q, id_d;
    logic               rtr_q, rtr_d;
    logic               ide_q, ide_d;
    logic [3:0]         dlc_q, dlc_d;
    logic [39:0]        data_q, data_d;
    logic               crc_err_q, crc_err_d;
    logic               dlc_err_q, dlc_err_d;
    logic               overrun_q, overrun_d;
    logic               filtered_q, filtered_d;

    logic [10:0] f_id;
    logic [3:0]  f_dlc;
    logic [3:0]  in_dlc;
    logic        f_dlc_ok;
    logic [6:0]  f_n;
    logic [39:0] f_data;
    logic [14:0] f_rx_crc;
    logic        crc_fb;
    logic        filter_hit;

`ifdef CAN_DEC_ID_FILTER_EN
    assign filter_hit = ((f_id ^ ACC_CODE) & ACC_MASK) != 11'd0;
`else
    logic [10:0] unused_acc;
    assign unused_acc = ACC_CODE & ACC_MASK;
    assign filter_hit = 1'b0;
`endif

    // Fields are stored MSB-first on the wire, so every field is bit-reversed here.
    always_comb begin
        f_id     = '0;
        f_dlc    = '0;
        in_dlc   = '0;
        f_data   = '0;
        f_rx_crc = '0;
        for (int k = 0; k < 11; k++) f_id[10-k] = frame_q[1+k];
        for (int k = 0; k < 4; k++) begin
            f_dlc[3-k]  = frame_q[15+k];
            in_dlc[3-k] = frm.i_Rx_Frame[15+k];
        end
        f_dlc_ok = (f_dlc <= 4'd5);
        f_n      = 7'd19 + {1'b0, f_dlc[2:0], 3'b000};
        for (int b = 0; b < 5; b++)
            for (int j = 0; j < 8; j++)
                if (f_dlc > 4'(b)) f_data[8*b+7-j] = frame_q[19+8*b+j];
        for (int k = 0; k < 15; k++) f_rx_crc[14-k] = frame_q[f_n + 7'(k)];
        crc_fb = frame_q[cnt_q] ^ crc_q[14];
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        id_d       = id_q;
        rtr_d      = rtr_q;
        ide_d      = ide_q;
        dlc_d      = dlc_q;
        data_d     = data_q;
        crc_err_d  = crc_err_q;
        dlc_err_d  = dlc_err_q;
        overrun_d  = frm.i_Rx_DV && (state_q != S_IDLE);
        filtered_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frm.i_Rx_DV) begin
                    frame_d = frm.i_Rx_Frame;
                    crc_d   = '0;
                    cnt_d   = '0;
                    state_d = (in_dlc <= 4'd5) ? S_CRC : S_CHECK;
                end
            end
            S_CRC: begin
                crc_d = {crc_q[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == f_n - 7'd1) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (filter_hit) begin
                    filtered_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    id_d      = f_id;
                    rtr_d     = frame_q[12];
                    ide_d     = frame_q[13];
                    dlc_d     = f_dlc;
                    valid_d   = 1'b1;
                    data_d    = f_dlc_ok ? f_data : 40'd0;
                    crc_err_d = f_dlc_ok && (crc_q != f_rx_crc);
                    dlc_err_d = !f_dlc_ok;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (frm.i_Frame_Ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            crc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            rtr_q      <= 1'b0;
            ide_q      <= 1'b0;
            dlc_q      <= '0;
            data_q     <= '0;
            crc_err_q  <= 1'b0;
            dlc_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            filtered_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            ide_q      <= ide_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
            crc_err_q  <= crc_err_d;
            dlc_err_q  <= dlc_err_d;
            overrun_q  <= overrun_d;
            filtered_q <= filtered_d;
        end
    end

    assign frm.o_Frame_Valid = valid_q;
    assign frm.o_Id          = id_q;
    assign frm.o_Rtr         = rtr_q;
    assign frm.o_Ide         = ide_q;
    assign frm.o_Dlc         = dlc_q;
    assign frm.o_Data        = data_q;
    assign frm.o_Crc_Err     = crc_err_q;
    assign frm.o_Dlc_Err     = dlc_err_q;
    assign frm.o_Overrun     = overrun_q;
    assign frm.o_Filtered    = filtered_q;
    assign frm.o_Busy        = (state_q != S_IDLE);
endmodule

// File: doc/can_frame_decoder.md
Name: can_frame_decoder

Overview:
Downstream stage of the CAN serial receiver. It consumes the 79-bit captured frame vector and its one-cycle data-valid strobe, then serially recomputes the CRC-15 over SOF, arbitration, control and data fields. It extracts the frame fields and presents a decoded frame with error flags to the controller through a valid/ready handshake.

Parameters:
FRAME_W, 79, width of input frame vector (fixed layout below; only 79 supported)
ACC_CODE, 11'h000, acceptance code (used only with CAN_DEC_ID_FILTER_EN)
ACC_MASK, 11'h000, acceptance mask; 1 = bit compared (only with CAN_DEC_ID_FILTER_EN)

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Frame is valid
i_Rx_Frame  in  79  captured frame, index 0 = first bit received
i_Frame_Ready  in  1  consumer accepts the decoded frame
o_Frame_Valid  out  1  decoded frame available
o_Id  out  11  identifier
o_Rtr  out  1  RTR bit
o_Ide  out  1  IDE bit
o_Dlc  out  4  data length code
o_Data  out  40  data bytes; byte0 in [7:0]
o_Crc_Err  out  1  received CRC differs from computed CRC
o_Dlc_Err  out  1  DLC > 5, frame does not fit FRAME_W
o_Overrun  out  1  one-cycle pulse: i_Rx_DV arrived while not IDLE, new frame dropped
o_Filtered  out  1  one-cycle pulse: frame rejected by acceptance filter
o_Busy  out  1  high whenever state != IDLE

Behaviour:
- Frame layout: [0] SOF; [1..11] ID, index 1 = ID[10]; [12] RTR; [13] IDE; [14] r0; [15..18] DLC, index 15 = DLC[3]; then 8*DLC data bits, first bit = MSB of byte0; then 15 CRC bits, first = CRC[14]; remaining bits ignored.
- Valid DLC 0..5 (19+8*DLC+15 <= 79). DLC 6..15 -> o_Dlc_Err.
- CRC-15: poly 0x4599, init 0, one bit per cycle: nxt = bit ^ crc[14]; crc = {crc[13:0],0} ^ (nxt ? 0x4599 : 0). Covers N = 19+8*DLC bits (indices 0..N-1).
- Reset: all outputs 0, state IDLE, CRC register 0, captured vector 0.
- FSM:
  IDLE: on i_Rx_DV, register i_Rx_Frame, clear CRC and bit counter. Next is CRC if DLC <= 5, else CHECK.
  CRC: process bit[counter] each cycle for N cycles, then CHECK.
  CHECK (1 cycle): load output fields. o_Crc_Err = (computed != received); DLC-error frames set o_Dlc_Err=1, o_Crc_Err=0, o_Data=0. Next is HOLD.
  HOLD: o_Frame_Valid=1, fields stable. When i_Frame_Ready=1, clear valid and go to IDLE next cycle.
- Latency: i_Rx_DV sampled in cycle 0 -> o_Frame_Valid high from cycle N+2 (cycle 2 for DLC error).
- Ready may be high in advance; transfer occurs in the first HOLD cycle with ready high. Ready outside HOLD is ignored.
- Unused o_Data bytes (index >= DLC) are 0. Frames with CRC error are still delivered, flagged.
- i_Rx_DV while state != IDLE (including the cycle HOLD exits): the frame is dropped, o_Overrun pulses one cycle, and the current frame is unaffected.
- Reset mid-operation: return to IDLE next edge, all outputs 0, pending frame lost.
- SOF and r0 values are not checked.

Optional Feature:
CAN_DEC_ID_FILTER_EN defined:
- In CHECK, if ((o_Id ^ ACC_CODE) & ACC_MASK) != 0, the frame is not presented. o_Filtered pulses one cycle and the FSM returns to IDLE.
- DLC-error frames are filtered the same way.
Undefined:
- Every frame is delivered; o_Filtered is tied 0.

Test Plan:
- All-zero frame, DLC=0, CRC field 0 -> valid at cycle 21, Id=0, Dlc=0, Crc_Err=0, Dlc_Err=0.
- Same frame with CRC field bit 14 set -> valid at cycle 21, Crc_Err=1.
- ID=0x123, DLC=2, data 0xA5,0x3C, CRC from bench model -> valid at cycle 37, Id=0x123, Data=40'h0000003CA5, Crc_Err=0. Hold ready low 5 cycles -> outputs stable, then single transfer.
- DLC=7 -> valid at cycle 2, Dlc_Err=1, Data=0, Crc_Err=0.
- Second i_Rx_DV 10 cycles after the first -> o_Overrun pulses once; the first frame is delivered unchanged and no second valid follows.
- Assert i_Reset mid-CRC -> o_Busy=0 and all outputs 0 next cycle. With CAN_DEC_ID_FILTER_EN, ACC_CODE=0x100, ACC_MASK=0x700: ID 0x123 is delivered, ID 0x223 gives an o_Filtered pulse and no valid.
